seg_mux_driver: RTL and testbench

SEG_MUX_DRIVER -- requirements
Module: seg_mux_driver

---
 rtl/seg_mux_driver.sv | 152 +++++++++++++++
 tb/tb_seg_mux_driver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_mux_driver.sv
// seg_mux_driver
//   Time-multiplexed driver for a two-digit seven-segment display.
//   Each frame shows the tens digit for ON_TIME cycles, blanks the display for
//   GAP_TIME cycles, then does the same for the ones digit. Both digit codes
//   are sampled once per frame, on the edge that starts the frame.
//
// Parameters
//   ON_TIME   cycles each digit is driven (1..255)
//   GAP_TIME  all-off cycles after each digit (1..255)
//   LZ_BLANK  1 = show a tens code of 0 as a blank digit
//
// Ports
//   clk_1khz  in   1 kHz clock, the only clock
//   rst_ni    in   asynchronous active-low reset
//   tens_i    in   [3:0] tens code: 0-9 numeral, 10 off, 11 'P', 12-15 '-'
//   ones_i    in   [3:0] ones code, same encoding
//   seg_o     out  [6:0] segments, active-high, bit0=a .. bit6=g
//   dig_en_o  out  [1:0] digit enables, bit1=tens, bit0=ones
//   frame_o   out  one-cycle pulse on the first cycle of each frame
//
// state     | meaning
// ----------+--------------------------------------------
// SHOW_TENS | tens digit enabled, shadow tens decoded
// GAP_T     | display dark after tens digit
// SHOW_ONES | ones digit enabled, shadow ones decoded
// GAP_O     | display dark after ones digit; reset state

module seg_mux_driver #(
  parameter int ON_TIME  = 4,
  parameter int GAP_TIME = 1,
  parameter int LZ_BLANK = 0
) (
  input  logic       clk_1khz,
  input  logic       rst_ni,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_en_o,
  output logic       frame_o
);

  typedef enum logic [1:0] {
    SHOW_TENS = 2'd0,
    GAP_T     = 2'd1,
    SHOW_ONES = 2'd2,
    GAP_O     = 2'd3
  } state_e;

  localparam logic [7:0] ON_LAST  = 8'(ON_TIME - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_TIME - 1);
  localparam logic [3:0] CODE_OFF = 4'd10;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      4'd10:   seg = 7'h00;
      4'd11:   seg = 7'h73;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] tens_sh_q, tens_sh_d;
  logic [3:0] ones_sh_q, ones_sh_d;
  logic [6:0] seg_q, seg_d;
  logic [1:0] dig_en_q, dig_en_d;
  logic       frame_q, frame_d;
  logic [7:0] dwell_last;
  logic       enter_tens;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 8'd1;
    tens_sh_d  = tens_sh_q;
    ones_sh_d  = ones_sh_q;
    seg_d      = 7'h00;
    dig_en_d   = 2'b00;
    dwell_last = ((state_q == SHOW_TENS) || (state_q == SHOW_ONES)) ? ON_LAST : GAP_LAST;

    if (timer_q == dwell_last) begin
      timer_d = 8'd0;
      case (state_q)
        SHOW_TENS: state_d = GAP_T;
        GAP_T:     state_d = SHOW_ONES;
        SHOW_ONES: state_d = GAP_O;
        default:   state_d = SHOW_TENS;
      endcase
    end

    enter_tens = (state_q == GAP_O) && (state_d == SHOW_TENS);
    if (enter_tens) begin
      tens_sh_d = tens_i;
      ones_sh_d = ones_i;
    end
    frame_d = enter_tens;

    // Outputs are registered from the next state so they change on the same
    // edge that enters the state, using the freshly captured shadow codes.
    case (state_d)
      SHOW_TENS: begin
        dig_en_d = 2'b10;
        if ((LZ_BLANK != 0) && (tens_sh_d == 4'd0)) seg_d = 7'h00;
        else                                        seg_d = decode(tens_sh_d);
      end
      SHOW_ONES: begin
        dig_en_d = 2'b01;
        seg_d    = decode(ones_sh_d);
      end
      default: begin
        dig_en_d = 2'b00;
        seg_d    = 7'h00;
      end
    endcase
  end

  always_ff @(posedge clk_1khz or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= GAP_O;
      timer_q   <= GAP_LAST;
      tens_sh_q <= CODE_OFF;
      ones_sh_q <= CODE_OFF;
      seg_q     <= 7'h00;
      dig_en_q  <= 2'b00;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tens_sh_q <= tens_sh_d;
      ones_sh_q <= ones_sh_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
      frame_q   <= frame_d;
    end
  end

  assign seg_o    = seg_q;
  assign dig_en_o = dig_en_q;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Testbench for seg_mux_driver: three instances (defaults, leading-zero
// blanking, ON_TIME=1/GAP_TIME=3). Expected per-cycle outputs
// {frame, dig_en, seg} are queued when stimulus is applied and popped when
// the selected instance is sampled on the falling clock edge.

module tb_seg_mux_driver;

  logic       clk_1khz;
  logic       rst_a, rst_b, rst_c;
  logic [3:0] tens_i, ones_i;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] dig_a, dig_b, dig_c;
  logic       frame_a, frame_b, frame_c;

  int compared   = 0;
  int mismatched = 0;

  logic [9:0] exp_q[$];

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h73, 7'h40, 7'h40, 7'h40, 7'h40
  };

  seg_mux_driver u_dflt (
    .clk_1khz(clk_1khz), .rst_ni(rst_a), .tens_i(tens_i), .ones_i(ones_i),
    .seg_o(seg_a), .dig_en_o(dig_a), .frame_o(frame_a)
  );

  seg_mux_driver #(.ON_TIME(4), .GAP_TIME(1), .LZ_BLANK(1)) u_lz (
    .clk_1khz(clk_1khz), .rst_ni(rst_b), .tens_i(tens_i), .ones_i(ones_i),
    .seg_o(seg_b), .dig_en_o(dig_b), .frame_o(frame_b)
  );

  seg_mux_driver #(.ON_TIME(1), .GAP_TIME(3), .LZ_BLANK(0)) u_fast (
    .clk_1khz(clk_1khz), .rst_ni(rst_c), .tens_i(tens_i), .ones_i(ones_i),
    .seg_o(seg_c), .dig_en_o(dig_c), .frame_o(frame_c)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  // Both digit enables must never be on together, in any instance.
  always @(negedge clk_1khz) begin
    compared = compared + 3;
    assert (dig_a !== 2'b11) else begin
      mismatched++; $error("FAIL onehot_dflt: observed=%b required=not 11", dig_a);
    end
    assert (dig_b !== 2'b11) else begin
      mismatched++; $error("FAIL onehot_lz: observed=%b required=not 11", dig_b);
    end
    assert (dig_c !== 2'b11) else begin
      mismatched++; $error("FAIL onehot_fast: observed=%b required=not 11", dig_c);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] dut_out(input int dut);
    case (dut)
      0:       return {frame_a, dig_a, seg_a};
      1:       return {frame_b, dig_b, seg_b};
      default: return {frame_c, dig_c, seg_c};
    endcase
  endfunction

  task automatic push_frame(input logic [6:0] t_seg, input logic [6:0] o_seg,
                            input int on_t, input int gap_t);
    for (int i = 0; i < on_t; i++)  exp_q.push_back({(i == 0), 2'b10, t_seg});
    for (int i = 0; i < gap_t; i++) exp_q.push_back({1'b0, 2'b00, 7'h00});
    for (int i = 0; i < on_t; i++)  exp_q.push_back({1'b0, 2'b01, o_seg});
    for (int i = 0; i < gap_t; i++) exp_q.push_back({1'b0, 2'b00, 7'h00});
  endtask

  task automatic push_off();
    exp_q.push_back(10'h000);
  endtask

  task automatic compare_now(input int dut, input string tag);
    logic [9:0] obs, expv;
    obs  = dut_out(dut);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed frame/dig/seg=%b/%b/%h required=%b/%b/%h",
             tag, obs[9], obs[8:7], obs[6:0], expv[9], expv[8:7], expv[6:0]);
    end
  endtask

  task automatic check_cycles(input int dut, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_1khz);
      compare_now(dut, tag);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tens_i = 4'd11; ones_i = 4'd1;
    repeat (2) @(negedge clk_1khz);
    push_off(); compare_now(0, "reset_dflt");
    push_off(); compare_now(1, "reset_lz");
    push_off(); compare_now(2, "reset_fast");

    // P1 on defaults, two frames
    rst_a = 1'b1;
    push_frame(7'h73, 7'h06, 4, 1);
    push_frame(7'h73, 7'h06, 4, 1);
    check_cycles(0, 20, "dflt_P1");

    // shadow capture: 4/2 latched, inputs changed to 7/7 during SHOW_ONES
    rst_a = 1'b0; tens_i = 4'd4; ones_i = 4'd2;
    @(negedge clk_1khz);
    push_off(); compare_now(0, "reset_hold");
    rst_a = 1'b1;
    push_frame(7'h66, 7'h5B, 4, 1);
    check_cycles(0, 6, "latch_42");
    tens_i = 4'd7; ones_i = 4'd7;
    check_cycles(0, 4, "latch_hold");
    push_frame(7'h07, 7'h07, 4, 1);
    check_cycles(0, 10, "latch_77");

    // code sweep, new codes applied during GAP_O before each frame
    for (int c = 0; c < 16; c++) begin
      tens_i = 4'(c); ones_i = 4'(15 - c);
      push_frame(SEG_TAB[c], SEG_TAB[15 - c], 4, 1);
      check_cycles(0, 10, "sweep");
    end

    // 0/5 without and with leading-zero blanking
    tens_i = 4'd0; ones_i = 4'd5;
    push_frame(7'h3F, 7'h6D, 4, 1);
    check_cycles(0, 10, "lz_off_05");
    rst_b = 1'b1;
    push_frame(7'h00, 7'h6D, 4, 1);
    check_cycles(1, 10, "lz_on_05");

    // short digits, long gaps: 8-cycle frame
    tens_i = 4'd8; ones_i = 4'd3;
    rst_c = 1'b1;
    push_frame(7'h7F, 7'h4F, 1, 3);
    push_frame(7'h7F, 7'h4F, 1, 3);
    check_cycles(2, 16, "fast_83");

    // asynchronous reset between edges during SHOW_ONES
    rst_a = 1'b0; tens_i = 4'd9; ones_i = 4'd6;
    @(negedge clk_1khz);
    push_off(); compare_now(0, "reset_pre_async");
    rst_a = 1'b1;
    push_frame(7'h6F, 7'h7D, 4, 1);
    check_cycles(0, 6, "pre_async");
    exp_q.delete();
    #2 rst_a = 1'b0;
    #1;
    push_off(); compare_now(0, "async_rst");
    push_off(); check_cycles(0, 1, "async_hold");
    rst_a = 1'b1;
    push_frame(7'h6F, 7'h7D, 4, 1);
    check_cycles(0, 10, "post_async");

    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL queue_drain: observed=%0d entries required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
